pdp8_mem_seq: RTL and testbench
===============================

Name: pdp8_mem_seq

Overview:
Memory-cycle sequencer directly upstream of the PDP-8 RAM/boot-ROM interface. Accepts one CPU memory request at a time: 15-bit field+address, read or write. Drives the RAM port (addr, data_in, rd, wr) with parameterised setup/strobe/hold timing so async SRAM timing is met. Captures read data and returns a one-cycle acknowledge to the CPU.

Parameters:
SETUP_CYC, 1, clocks addr/data stable before strobe (range 1..15)
PULSE_CYC, 2, clocks rd/wr strobe asserted (range 1..15)
HOLD_CYC, 1, clocks addr/data held after strobe deasserts (range 1..15)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cpu_req  in  1  request valid; sampled only when cpu_ready=1
cpu_we  in  1  1=write, 0=read; qualified by cpu_req
cpu_addr  in  15  {field[2:0], addr[11:0]}
cpu_wdata  in  12  write data
cpu_ready  out  1  sequencer idle, can accept request
cpu_ack  out  1  one-cycle pulse, cycle complete
cpu_rdata  out  12  read data, valid from cpu_ack until next accepted read
ram_addr  out  15  to RAM interface addr
ram_data_in  out  12  to RAM interface data_in
ram_data_out  in  12  from RAM interface data_out (ROM/SRAM muxed)
ram_rd  out  1  read strobe, active high
ram_wr  out  1  write strobe, active high

Behaviour:
- Reset (async assert, sync release): state IDLE; cpu_ready=1, cpu_ack=0, cpu_rdata=0, ram_addr=0, ram_data_in=0, ram_rd=0, ram_wr=0, counter=0.
- All outputs registered; no combinational path from cpu_* inputs to ram_*.
- Accept: rising edge with state IDLE and cpu_req=1 -> latch cpu_addr into ram_addr, cpu_wdata into ram_data_in (writes only; unchanged on reads), latch op; go SETUP, load counter SETUP_CYC-1. cpu_req while not IDLE is ignored; the CPU holds it until ready.
- States:
  - IDLE: ready=1.
  - SETUP: SETUP_CYC clocks; read -> ram_rd=1, write -> strobes 0.
  - STROBE: PULSE_CYC clocks; read -> ram_rd=1; write -> ram_wr=1.
  - HOLD: HOLD_CYC clocks; strobes 0; ram_addr/ram_data_in unchanged.
  - DONE: 1 clock; cpu_ack=1; then IDLE.
- Counter decrements each clock; transition when it reads 0 at the edge. Next phase count is loaded on that transition.
- Read capture: cpu_rdata <= ram_data_out on the edge ending the last STROBE clock, while ram_rd still 1. Writes never change cpu_rdata.
- ram_wr and ram_rd never asserted together. ram_wr never rises or falls in the same edge ram_addr changes.
- Latency from accepting edge to cpu_ack high: SETUP_CYC+PULSE_CYC+HOLD_CYC+1 clocks (defaults: 5). Minimum request-to-request spacing is that plus 1 (IDLE clock).
- cpu_ready=0 in every state except IDLE, including DONE. No back-to-back accept in DONE.
- Address wrap is not applicable: address passed verbatim; 077777 is legal.
- reset_n asserted mid-cycle: ram_wr/ram_rd drop immediately (async). The aborted write may be partial; no ack is issued.
- Parameters outside 1..15 are a configuration error; a simulation-only check flags them at time 0.

Decomposition:
- Shared package/defines file pdp8_mem_defs: state encodings (IDLE, SETUP, STROBE, HOLD, DONE, 3 bits), op encoding (MEM_RD=0, MEM_WR=1), counter width constant (4).
- Single module; the phase counter stays inline. No sub-module is warranted.

Test Plan:
- Write defaults: req we=1 addr=000200 wdata=7402 -> ram_wr high exactly clocks 2-3 after accept; ram_addr=000200 and ram_data_in=7402 stable clocks 1-4; ack at clock 5.
- Read defaults: RAM model returns 1234 at 000200 -> ram_rd high clocks 1-3, wr never high; cpu_rdata=1234 when ack pulses at clock 5; ready back at clock 6.
- Request while busy: second req asserted at clock 2 with addr=000300 -> ignored until IDLE; accepted at clock 6; ram_addr stays 000200 through first cycle.
- Parameters SETUP=3 PULSE=4 HOLD=2, write to 077777 -> wr high clocks 4-7, ack at clock 10, address passed unwrapped.
- Async reset mid-STROBE of a write: reset_n low at clock 2.5 -> ram_wr=0 same time, no ack; after release ready=1 and a new read completes normally.
- Reads of boot-ROM and SRAM regions back-to-back -> cpu_rdata tracks ram_data_out at each capture edge; write data never leaks to cpu_rdata.

Source files
------------

// File: rtl/pdp8_mem_seq_pkg.sv
// pdp8_mem_seq_pkg: shared state, op and counter definitions for the PDP-8 memory sequencer
package pdp8_mem_seq_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_t;
    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;
    localparam int CNT_W = 4;
endpackage

// File: rtl/pdp8_mem_seq.sv
// pdp8_mem_seq: runs one CPU memory request through setup/strobe/hold timing on the async RAM port
module pdp8_mem_seq
    import pdp8_mem_seq_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [11:0] cpu_wdata,
    output logic        cpu_ready,
    output logic        cpu_ack,
    output logic [11:0] cpu_rdata,
    output logic [14:0] ram_addr,
    output logic [11:0] ram_data_in,
    input  logic [11:0] ram_data_out,
    output logic        ram_rd,
    output logic        ram_wr
);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    if (SETUP_CYC < 1 || SETUP_CYC > 15 || PULSE_CYC < 1 || PULSE_CYC > 15 ||
        HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_param_err
        $error("pdp8_mem_seq: timing parameters must lie in 1..15");
    end

    state_t           state;
    logic             op;
    logic [CNT_W-1:0] cnt;
    logic             last;

    assign last = cnt == '0;

    // Strobes are registered one phase ahead so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            op          <= MEM_RD;
            cnt         <= '0;
            cpu_ready   <= 1'b1;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
            ram_addr    <= '0;
            ram_data_in <= '0;
            ram_rd      <= 1'b0;
            ram_wr      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (cpu_req) begin
                    state     <= ST_SETUP;
                    cnt       <= SETUP_LD;
                    op        <= cpu_we;
                    ram_addr  <= cpu_addr;
                    ram_rd    <= cpu_we == MEM_RD;
                    cpu_ready <= 1'b0;
                    if (cpu_we == MEM_WR) ram_data_in <= cpu_wdata;
                end
                ST_SETUP: if (last) begin
                    state  <= ST_STROBE;
                    cnt    <= PULSE_LD;
                    ram_wr <= op == MEM_WR;
                end else cnt <= cnt - 1'b1;
                ST_STROBE: if (last) begin
                    state  <= ST_HOLD;
                    cnt    <= HOLD_LD;
                    ram_rd <= 1'b0;
                    ram_wr <= 1'b0;
                    if (op == MEM_RD) cpu_rdata <= ram_data_out;
                end else cnt <= cnt - 1'b1;
                ST_HOLD: if (last) begin
                    state   <= ST_DONE;
                    cpu_ack <= 1'b1;
                end else cnt <= cnt - 1'b1;
                ST_DONE: begin
                    state     <= ST_IDLE;
                    cpu_ack   <= 1'b0;
                    cpu_ready <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pdp8_mem_seq.sv
// tb_pdp8_mem_seq: randomized transactions on a default and a slow-timed sequencer against a phase-timeline model
module tb_pdp8_mem_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req[2];
    logic        cpu_we[2];
    logic [14:0] cpu_addr[2];
    logic [11:0] cpu_wdata[2];
    logic        cpu_ready[2];
    logic        cpu_ack[2];
    logic [11:0] cpu_rdata[2];
    logic [14:0] ram_addr[2];
    logic [11:0] ram_data_in[2];
    logic [11:0] ram_data_out[2];
    logic        ram_rd[2];
    logic        ram_wr[2];

    logic [11:0] mem[32768];
    logic [11:0] exp_rdata[2];
    logic [11:0] exp_din[2];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Data is only valid while the read strobe is high; otherwise the bus shows the complement.
    assign ram_data_out[0] = ram_rd[0] ? mem[ram_addr[0]] : ~mem[ram_addr[0]];
    assign ram_data_out[1] = ram_rd[1] ? mem[ram_addr[1]] : ~mem[ram_addr[1]];

    pdp8_mem_seq u_dut0 (
        .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]),
        .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]), .cpu_ready(cpu_ready[0]),
        .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]), .ram_addr(ram_addr[0]),
        .ram_data_in(ram_data_in[0]), .ram_data_out(ram_data_out[0]),
        .ram_rd(ram_rd[0]), .ram_wr(ram_wr[0])
    );

    pdp8_mem_seq #(.SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]),
        .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]), .cpu_ready(cpu_ready[1]),
        .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]), .ram_addr(ram_addr[1]),
        .ram_data_in(ram_data_in[1]), .ram_data_out(ram_data_out[1]),
        .ram_rd(ram_rd[1]), .ram_wr(ram_wr[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input int d);
        check($sformatf("d%0d rst ready", d), 32'(cpu_ready[d]), 1);
        check($sformatf("d%0d rst ack", d), 32'(cpu_ack[d]), 0);
        check($sformatf("d%0d rst rdata", d), 32'(cpu_rdata[d]), 0);
        check($sformatf("d%0d rst addr", d), 32'(ram_addr[d]), 0);
        check($sformatf("d%0d rst din", d), 32'(ram_data_in[d]), 0);
        check($sformatf("d%0d rst rd", d), 32'(ram_rd[d]), 0);
        check($sformatf("d%0d rst wr", d), 32'(ram_wr[d]), 0);
    endtask

    // Period k=1 is the clock following the accepting edge; the phases then follow back to back.
    task automatic do_txn(input int d, input logic w, input logic [14:0] a,
                          input logic [11:0] wd, input bit busy);
        int s, p, h, l;
        s = d ? 3 : 1;
        p = d ? 4 : 2;
        h = d ? 2 : 1;
        l = s + p + h + 1;
        @(negedge clk);
        check($sformatf("d%0d idle ready", d), 32'(cpu_ready[d]), 1);
        check($sformatf("d%0d idle ack", d), 32'(cpu_ack[d]), 0);
        cpu_req[d] = 1'b1;
        cpu_we[d] = w;
        cpu_addr[d] = a;
        cpu_wdata[d] = wd;
        @(posedge clk);
        #1;
        cpu_req[d] = 1'b0;
        cpu_addr[d] = 15'($urandom);
        cpu_wdata[d] = 12'($urandom);
        if (w) exp_din[d] = wd;
        for (int k = 1; k <= l; k++) begin
            @(negedge clk);
            if (k == 2 && busy) begin
                cpu_req[d] = 1'b1;
                cpu_we[d] = 1'($urandom);
            end
            if (k == s + p + 1 && !w) exp_rdata[d] = mem[a];
            check($sformatf("d%0d k%0d ready", d, k), 32'(cpu_ready[d]), 0);
            check($sformatf("d%0d k%0d ack", d, k), 32'(cpu_ack[d]), 32'(k == l));
            check($sformatf("d%0d k%0d rd", d, k), 32'(ram_rd[d]), 32'(!w && k <= s + p));
            check($sformatf("d%0d k%0d wr", d, k), 32'(ram_wr[d]), 32'(w && k > s && k <= s + p));
            check($sformatf("d%0d k%0d addr", d, k), 32'(ram_addr[d]), 32'(a));
            check($sformatf("d%0d k%0d din", d, k), 32'(ram_data_in[d]), 32'(exp_din[d]));
            check($sformatf("d%0d k%0d rdata", d, k), 32'(cpu_rdata[d]), 32'(exp_rdata[d]));
        end
        cpu_req[d] = 1'b0;
        if (w) mem[a] = wd;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 12'($urandom);
        for (int d = 0; d < 2; d++) begin
            cpu_req[d] = 1'b0;
            cpu_we[d] = 1'b0;
            cpu_addr[d] = '0;
            cpu_wdata[d] = '0;
            exp_rdata[d] = '0;
            exp_din[d] = '0;
        end
        #12;
        check_reset_state(0);
        check_reset_state(1);
        @(negedge clk);
        reset_n = 1'b1;

        mem[15'o00200] = 12'o1234;
        do_txn(0, 1'b0, 15'o00200, 12'o0000, 1'b1);
        do_txn(0, 1'b1, 15'o00200, 12'o7402, 1'b1);
        do_txn(0, 1'b0, 15'o00200, 12'o0000, 1'b0);
        do_txn(0, 1'b1, 15'o00300, 12'o5555, 1'b0);
        do_txn(1, 1'b1, 15'o77777, 12'o4321, 1'b1);
        do_txn(1, 1'b0, 15'o77777, 12'o0000, 1'b0);

        // Abort a write in the middle of its strobe.
        @(negedge clk);
        cpu_req[0] = 1'b1;
        cpu_we[0] = 1'b1;
        cpu_addr[0] = 15'o01000;
        cpu_wdata[0] = 12'o7777;
        @(posedge clk);
        #1;
        cpu_req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort wr before", 32'(ram_wr[0]), 1);
        #1;
        reset_n = 1'b0;
        #1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        exp_din[0] = '0;
        exp_din[1] = '0;
        check_reset_state(0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort no ack", 32'(cpu_ack[0]), 0);
        end
        do_txn(0, 1'b0, 15'o01000, 12'o0000, 1'b0);

        // Alternate boot-ROM (field 7) and SRAM regions with random ops.
        for (int n = 0; n < 30; n++) begin
            for (int d = 0; d < 2; d++) begin
                logic [14:0] a;
                a = 15'($urandom);
                if (n[0]) a[14:12] = 3'o7;
                else a[14:12] = 3'($urandom_range(0, 6));
                if ($urandom_range(0, 3) == 0) a = 15'o77777;
                do_txn(d, 1'($urandom), a, 12'($urandom), 1'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
